tt_um_nibble_serial_sub8: RTL
=============================

# tt_um_nibble_serial_sub8

- Sequential 8-bit subtractor (D = A − B) for the Tiny Tapeout tile.
- It is the inverse-operation companion to the 4-bit parallel-prefix adder: operands arrive one nibble pair per handshake, low nibble first.
- A 4-bit prefix subtract datapath is applied twice, with a registered borrow linking the two halves.
- The full byte result, borrow-out, and (optionally) signed overflow are presented on completion.

## Interface
Parameters: none.

- clk  input  1  rising-edge clock
- rst_n  input  1  reset; asynchronous, active-low
- ena  input  1  always 1 when powered; ignored
- ui_in  input  8  [3:0] = current nibble of A, [7:4] = current nibble of B
- uio_in  input  8  [0] = in_valid strobe; [1] = abort; [7:2] ignored
- uo_out  output  8  result byte D of last completed operation
- uio_out  output  8  [2] = done, [3] = borrow_out, [4] = busy, [5] = ovf; all other bits 0
- uio_oe  output  8  constant 8'h3C (uio[5:2] outputs, rest inputs)

## Operation
- FSM states: S_LO (awaiting low nibbles), S_HI (awaiting high nibbles), S_DONE (result valid).
- **Nibble subtract:** d = a − b − bin, 4 bits wide, computed as a + ~b + ~bin through a 4-bit prefix carry chain; bout = ~carry4.
- **S_LO + in_valid:**
  - Compute d with bin = 0.
  - Store d in lo_stage[3:0] and bout in borrow_reg.
  - Capture A[3]… not needed; go to S_HI.
- **S_HI + in_valid:**
  - Compute d with bin = borrow_reg.
  - uo_out ← {d, lo_stage}; borrow_out ← bout.
  - ovf ← (a[3]^b[3]) & (a[3]^d[3]), i.e. the signed 8-bit overflow of the full operation.
  - Go to S_DONE.
- **S_DONE:**
  - done = 1; outputs held.
  - in_valid is treated as a new low nibble (same as S_LO): done clears, go to S_HI.
- **abort (uio_in[1]):**
  - Synchronous; has priority over in_valid in every state.
  - Next state S_LO; done = 0; borrow_reg = 0.
  - uo_out, borrow_out and ovf keep their last completed values.
- **No in_valid:** state and all registers hold.
- **Registered outputs:** done = (state == S_DONE); busy = (state == S_HI).
- **Output stability:** uo_out changes only on completion, so the previous result stays stable while the next operation is in flight.
- **Arithmetic:** unsigned modulo 256; borrow_out = 1 iff A < B (unsigned).
- **Reset (rst_n low, asynchronous):**
  - State → S_LO.
  - uo_out = 8'h00; uio_out = 8'h00 (done, borrow_out, busy, ovf all 0).
  - lo_stage = 0; borrow_reg = 0.
  - uio_oe = 8'h3C at all times, including during reset.

## Timing
- in_valid and abort are sampled on the rising edge of clk; one nibble pair is consumed per edge with in_valid = 1.
- in_valid may remain high on consecutive cycles; each edge consumes the next nibble.
- Latency: uo_out, borrow_out, ovf and done update at the same edge that samples the high nibble pair; done is visible in the following cycle.
- Throughput: one result per 2 valid cycles, back-to-back with no bubble from S_DONE.
- busy is high for every cycle spent in S_HI.
- Reset mid-operation (in S_HI) discards the pending low nibble immediately, with no clock required.
- Release of rst_n: the first edge after deassertion may already accept a low nibble.

## Configuration
- SUB_SIGNED_OVF_EN
  - **Defined:** the ovf register and logic are compiled in; uio_out[5] = ovf as defined above; reset value 0.
  - **Undefined:** no ovf register exists; uio_out[5] is tied 0.
  - uio_oe stays 8'h3C either way.

## Test plan
- Reset: hold rst_n low with random ui_in/uio_in, including mid-S_HI → uo_out = 8'h00, uio_out = 8'h00, uio_oe = 8'h3C, no clock needed.
- 0x53 − 0x21: valid with ui_in = 8'h13, then ui_in = 8'h25 on the next edge → uo_out = 8'h32, borrow_out 0, done = 1 one cycle after the second edge, busy high for exactly one cycle.
- Inter-nibble borrow, 0x20 − 0x01: ui_in = 8'h10, then 8'h02 → uo_out = 8'h1F, borrow_out 0.
- Underflow and overflow:
  - 0x00 − 0x01 (8'h10, 8'h00) → uo_out = 8'hFF, borrow_out 1, ovf 0.
  - 0x80 − 0x01 (8'h10, 8'h08) → uo_out = 8'h7F, borrow_out 0, ovf 1 with SUB_SIGNED_OVF_EN defined, 0 without.
- Abort: low pair 8'h10, then abort + valid on the same edge → state S_LO, busy 0, uo_out unchanged.
  - Follow with pairs 8'h13, 8'h25 → 8'h32, which proves the stale borrow was cleared.
- Back-to-back: four consecutive valid cycles (8'h13, 8'h25, 8'h10, 8'h02) → done pulses after the 2nd edge (uo_out = 8'h32) and again after the 4th edge (uo_out = 8'h1F).
  - During the 3rd cycle done = 0 and uo_out still reads 8'h32.

Source files
------------

// File: rtl/tt_um_nibble_serial_sub8.sv
// tt_um_nibble_serial_sub8: sequential 8-bit subtractor D = A - B.
// Operands arrive one nibble pair per in_valid strobe, low nibble first.
// A single 4-bit prefix-carry subtract slice is reused for both halves,
// and a registered borrow carries the low-half result into the high half.
// Optional feature macro: SUB_SIGNED_OVF_EN (signed overflow flag on uio_out[5]).
//
// Handshake: in_valid (uio_in[0]) is a per-edge strobe with no back-pressure;
// every rising edge with in_valid=1 consumes one nibble pair. abort (uio_in[1])
// is sampled on the same edge and wins over in_valid.
module tt_um_nibble_serial_sub8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    S_LO   = 2'd0,
    S_HI   = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_lo_stage;
  logic       r_borrow;
  logic [7:0] r_result;
  logic       r_borrow_out;
  logic       r_ovf;

  logic [3:0] w_nib_a;
  logic [3:0] w_nib_b;
  logic       w_valid;
  logic       w_abort;
  logic       w_bin;
  logic [4:0] w_sub;
  logic [3:0] w_d;
  logic       w_bout;
  logic       w_unused;

  // 4-bit subtract a - b - bin as a + ~b + ~bin through a two-level prefix
  // carry network; returns {borrow_out, difference}.
  function automatic logic [4:0] nib_sub(input logic [3:0] a,
                                         input logic [3:0] b,
                                         input logic       bin);
    logic [3:0] bn;
    logic [3:0] g;
    logic [3:0] p;
    logic       c0, c1, c2, c3, c4;
    logic       g10, p10, g32, p32;
    bn  = ~b;
    g   = a & bn;
    p   = a ^ bn;
    c0  = ~bin;
    g10 = g[1] | (p[1] & g[0]);
    p10 = p[1] & p[0];
    g32 = g[3] | (p[3] & g[2]);
    p32 = p[3] & p[2];
    c1  = g[0] | (p[0] & c0);
    c2  = g10 | (p10 & c0);
    c3  = g[2] | (p[2] & c2);
    c4  = g32 | (p32 & c2);
    return {~c4, p ^ {c3, c2, c1, c0}};
  endfunction

  assign w_nib_a  = ui_in[3:0];
  assign w_nib_b  = ui_in[7:4];
  assign w_valid  = uio_in[0];
  assign w_abort  = uio_in[1];
  // Only the high half consumes the stored borrow; the low half starts clean.
  assign w_bin    = (r_state == S_HI) ? r_borrow : 1'b0;
  assign w_sub    = nib_sub(w_nib_a, w_nib_b, w_bin);
  assign w_d      = w_sub[3:0];
  assign w_bout   = w_sub[4];
  assign w_unused = &{1'b0, ena, uio_in[7:2]};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_LO;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: abort returns to S_LO; in S_DONE a strobe starts a new operation.
  always_comb begin
    w_state_nxt = r_state;
    if (w_abort) begin
      w_state_nxt = S_LO;
    end else if (w_valid) begin
      case (r_state)
        S_LO:    w_state_nxt = S_HI;
        S_HI:    w_state_nxt = S_DONE;
        S_DONE:  w_state_nxt = S_HI;
        default: w_state_nxt = S_LO;
      endcase
    end
  end

  // Datapath: stage the low half, commit the full byte on the high half.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lo_stage   <= 4'h0;
      r_borrow     <= 1'b0;
      r_result     <= 8'h00;
      r_borrow_out <= 1'b0;
    end else if (w_abort) begin
      r_borrow <= 1'b0;
    end else if (w_valid) begin
      if (r_state == S_HI) begin
        r_result     <= {w_d, r_lo_stage};
        r_borrow_out <= w_bout;
      end else begin
        r_lo_stage <= w_d;
        r_borrow   <= w_bout;
      end
    end
  end

`ifdef SUB_SIGNED_OVF_EN
  // Signed overflow: operands of different sign and result sign differs from A.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (!w_abort && w_valid && (r_state == S_HI)) begin
      r_ovf <= (w_nib_a[3] ^ w_nib_b[3]) & (w_nib_a[3] ^ w_d[3]);
    end
  end
`else
  assign r_ovf = 1'b0;
`endif

  assign uo_out  = r_result;
  assign uio_out = {2'b00, r_ovf, (r_state == S_HI), r_borrow_out,
                    (r_state == S_DONE), 2'b00};
  assign uio_oe  = 8'h3C;

endmodule
